iram_uart_loader: RTL



---
 rtl/iram_uart_loader.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/iram_uart_loader.sv
// UART frame loader: SYNC, LEN_LO, LEN_HI, 4*N little-endian data bytes, CSUM -> IRAM writes; holds the core in reset until a good frame.
// Optional inter-byte timeout is enabled with `define LOADER_TIMEOUT_EN.
module iram_uart_loader #(
    parameter int         ADDR_W      = 12,
    parameter logic [7:0] SYNC_BYTE   = 8'h55,
    parameter int         TIMEOUT_CYC = 100000
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              core_rst,
    output logic              load_done,
    output logic              load_err,
    output logic [2:0]        dbg_state_o
);

    // Byte handshake: a byte is consumed on any rising edge where rx_valid & rx_ready.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN0 = 3'd1,
        S_LEN1 = 3'd2,
        S_DATA = 3'd3,
        S_CSUM = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    state_t            state_q;
    logic [7:0]        len_lo_q;
    logic [15:0]       len_q;
    logic [ADDR_W:0]   word_cnt_q;
    logic [1:0]        byte_idx_q;
    logic [7:0]        csum_q;
    logic [23:0]       word_buf_q;
    logic              rx_ready_q;
    logic              ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [31:0]       ram_wdata_q;
    logic              core_rst_q;
    logic              load_done_q;
    logic              load_err_q;

    logic              accept;
    logic              is_sync;
    logic [15:0]       len_d;
    logic [ADDR_W:0]   word_cnt_d;

    assign accept     = rx_valid & rx_ready_q;
    assign is_sync    = (rx_data == SYNC_BYTE);
    assign len_d      = {rx_data, len_lo_q};
    assign word_cnt_d = word_cnt_q + 1'b1;

`ifdef LOADER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_q;
    logic             timed_state;
    assign timed_state = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                         (state_q == S_DATA) || (state_q == S_CSUM);
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYC == 0);
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= S_IDLE;
            len_lo_q    <= '0;
            len_q       <= '0;
            word_cnt_q  <= '0;
            byte_idx_q  <= '0;
            csum_q      <= '0;
            word_buf_q  <= '0;
            rx_ready_q  <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            core_rst_q  <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            rx_ready_q <= 1'b1;
            ram_we_q   <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (accept && is_sync) begin
                        state_q     <= S_LEN0;
                        word_cnt_q  <= '0;
                        byte_idx_q  <= '0;
                        csum_q      <= '0;
                        core_rst_q  <= 1'b1;
                        load_done_q <= 1'b0;
                        load_err_q  <= 1'b0;
                    end
                end
                S_LEN0: begin
                    if (accept) begin
                        len_lo_q <= rx_data;
                        state_q  <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (accept) begin
                        len_q <= len_d;
                        if (32'(len_d) > (32'd1 << ADDR_W)) begin
                            state_q    <= S_ERR;
                            load_err_q <= 1'b1;
                        end else if (len_d == 16'd0) begin
                            state_q <= S_CSUM;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        csum_q     <= csum_q + rx_data;
                        byte_idx_q <= byte_idx_q + 2'd1;
                        case (byte_idx_q)
                            2'd0: word_buf_q[7:0]   <= rx_data;
                            2'd1: word_buf_q[15:8]  <= rx_data;
                            2'd2: word_buf_q[23:16] <= rx_data;
                            default: begin
                                ram_we_q    <= 1'b1;
                                ram_addr_q  <= word_cnt_q[ADDR_W-1:0];
                                ram_wdata_q <= {rx_data, word_buf_q};
                                word_cnt_q  <= word_cnt_d;
                                if (32'(word_cnt_d) == 32'(len_q)) begin
                                    state_q <= S_CSUM;
                                end
                            end
                        endcase
                    end
                end
                S_CSUM: begin
                    if (accept) begin
                        if (rx_data == csum_q) begin
                            state_q     <= S_DONE;
                            load_done_q <= 1'b1;
                            core_rst_q  <= 1'b0;
                        end else begin
                            state_q    <= S_ERR;
                            load_err_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
`ifdef LOADER_TIMEOUT_EN
            // A stalled byte stream inside a frame aborts to ERR; accepted bytes win over expiry.
            if (timed_state && !accept) begin
                if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    tmo_q       <= '0;
                    state_q     <= S_ERR;
                    load_err_q  <= 1'b1;
                    load_done_q <= 1'b0;
                    core_rst_q  <= 1'b1;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
            end else begin
                tmo_q <= '0;
            end
`endif
        end
    end

    assign rx_ready    = rx_ready_q;
    assign ram_we      = ram_we_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wdata   = ram_wdata_q;
    assign core_rst    = core_rst_q;
    assign load_done   = load_done_q;
    assign load_err    = load_err_q;
    assign dbg_state_o = state_q;

endmodule
